generador_siguiente_pc: RTL and testbench

GENERADOR_SIGUIENTE_PC -- requirements
Module: generador_siguiente_pc

---
 rtl/generador_siguiente_pc.sv | 154 +++++++++++++++
 tb/tb_generador_siguiente_pc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_siguiente_pc.sv
// Next-PC generator and instruction fetch sequencer.
// Each instruction goes through three steps: request it from instruction
// memory, wait for the response, then hold it for downstream. While an
// instruction is held, the PC advances by 4 once it is consumed, or jumps
// when a redirect arrives.
//
// Handshake semantics: a fetch request is accepted on any rising edge where
// mem_peticion and mem_listo are both high. The response is a single-cycle
// mem_valido pulse, and it is honoured only while waiting for that request.
// A delivered instruction is consumed on any cycle with instruccion_valida=1
// and detener=0.
module generador_siguiente_pc #(
  parameter int               ANCHO     = 64,
  parameter logic [ANCHO-1:0] DIR_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] direccion_actual,
  input  logic             salto_tomado,
  input  logic [ANCHO-1:0] direccion_salto,
  input  logic             detener,
  input  logic             mem_listo,
  input  logic             mem_valido,
  input  logic [31:0]      mem_instruccion,
  output logic             mem_peticion,
  output logic [ANCHO-1:0] mem_direccion,
  output logic [31:0]      instruccion,
  output logic             instruccion_valida,
  output logic [ANCHO-1:0] nueva_direccion,
  output logic             actualizar_pc,
  output logic [1:0]       estado_fsm
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    PEDIR    = 2'd1,
    ESPERAR  = 2'd2,
    ENTREGAR = 2'd3
  } estado_t;

  // Redirect targets are word aligned: the two low bits are dropped.
  localparam logic [ANCHO-1:0] MASCARA_ALINEADA = {{(ANCHO-2){1'b1}}, 2'b00};

  estado_t          estado, estado_sig;
  logic [31:0]      instr_sig;
  logic             valida_sig;
  logic             descartar, descartar_sig;
  logic [ANCHO-1:0] destino_guardado, destino_guardado_sig;
  logic [ANCHO-1:0] destino;

  assign destino       = direccion_salto & MASCARA_ALINEADA;
  assign mem_direccion = direccion_actual;
  assign estado_fsm    = estado;

  // State and data registers. The outstanding request is abandoned on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado             <= INACTIVO;
      instruccion        <= '0;
      instruccion_valida <= 1'b0;
      descartar          <= 1'b0;
      destino_guardado   <= '0;
    end else begin
      estado             <= estado_sig;
      instruccion        <= instr_sig;
      instruccion_valida <= valida_sig;
      descartar          <= descartar_sig;
      destino_guardado   <= destino_guardado_sig;
    end
  end

  // Next state, PC update and fetch request. A redirect that arrives while a
  // request is in flight is recorded and applied when the response returns,
  // so the PC never changes under an outstanding fetch.
  always_comb begin
    estado_sig           = estado;
    instr_sig            = instruccion;
    valida_sig           = instruccion_valida;
    descartar_sig        = descartar;
    destino_guardado_sig = destino_guardado;
    mem_peticion         = 1'b0;
    actualizar_pc        = 1'b0;
    nueva_direccion      = direccion_actual;

    if (reset) begin
      actualizar_pc   = 1'b1;
      nueva_direccion = DIR_RESET;
    end else begin
      case (estado)
        INACTIVO: begin
          estado_sig = PEDIR;
          if (salto_tomado) begin
            actualizar_pc   = 1'b1;
            nueva_direccion = destino;
          end
        end

        PEDIR: begin
          mem_peticion = 1'b1;
          if (mem_listo) begin
            estado_sig = ESPERAR;
            if (salto_tomado) begin
              descartar_sig        = 1'b1;
              destino_guardado_sig = destino;
            end
          end else if (salto_tomado) begin
            actualizar_pc   = 1'b1;
            nueva_direccion = destino;
          end
        end

        ESPERAR: begin
          if (salto_tomado && mem_valido) begin
            actualizar_pc   = 1'b1;
            nueva_direccion = destino;
            descartar_sig   = 1'b0;
            estado_sig      = PEDIR;
          end else if (salto_tomado) begin
            descartar_sig        = 1'b1;
            destino_guardado_sig = destino;
          end else if (mem_valido) begin
            if (descartar) begin
              actualizar_pc   = 1'b1;
              nueva_direccion = destino_guardado;
              descartar_sig   = 1'b0;
              estado_sig      = PEDIR;
            end else begin
              instr_sig  = mem_instruccion;
              valida_sig = 1'b1;
              estado_sig = ENTREGAR;
            end
          end
        end

        ENTREGAR: begin
          if (salto_tomado) begin
            valida_sig      = 1'b0;
            actualizar_pc   = 1'b1;
            nueva_direccion = destino;
            estado_sig      = PEDIR;
          end else if (!detener) begin
            valida_sig      = 1'b0;
            actualizar_pc   = 1'b1;
            nueva_direccion = direccion_actual + ANCHO'(4);
            estado_sig      = PEDIR;
          end
        end

        default: estado_sig = INACTIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_generador_siguiente_pc.sv
// Testbench for generador_siguiente_pc: directed scenarios followed by a
// randomized run checked against a fetch-stream reference model.
module tb_generador_siguiente_pc;

  localparam int ANCHO = 64;

  // ---------------- clock / reset / environment ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ANCHO-1:0] pc;
  logic             salto_tomado = 1'b0;
  logic [ANCHO-1:0] direccion_salto = '0;
  logic             detener = 1'b0;
  logic             mem_listo = 1'b0;
  logic             mem_valido = 1'b0;
  logic [31:0]      mem_instruccion = '0;
  logic             mem_peticion;
  logic [ANCHO-1:0] mem_direccion;
  logic [31:0]      instruccion;
  logic             instruccion_valida;
  logic [ANCHO-1:0] nueva_direccion;
  logic             actualizar_pc;
  logic [1:0]       estado_fsm;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generador_siguiente_pc #(.ANCHO(ANCHO), .DIR_RESET(64'h0)) dut (
    .clk                (clk),
    .reset              (reset),
    .direccion_actual   (pc),
    .salto_tomado       (salto_tomado),
    .direccion_salto    (direccion_salto),
    .detener            (detener),
    .mem_listo          (mem_listo),
    .mem_valido         (mem_valido),
    .mem_instruccion    (mem_instruccion),
    .mem_peticion       (mem_peticion),
    .mem_direccion      (mem_direccion),
    .instruccion        (instruccion),
    .instruccion_valida (instruccion_valida),
    .nueva_direccion    (nueva_direccion),
    .actualizar_pc      (actualizar_pc),
    .estado_fsm         (estado_fsm)
  );

  // The PC register that sits outside the block: loads every rising edge.
  always @(posedge clk) pc <= nueva_direccion;

  // Instruction memory content as a function of address; address 0 holds 8B020020.
  function automatic logic [31:0] dato_de(input logic [63:0] a);
    return 32'h8B020020 ^ a[33:2] ^ a[63:32];
  endfunction

  // ---------------- instruction memory model ----------------
  int               lat = 1;        // response latency for the next accepted request
  bit               espurio = 1'b0; // allow stray mem_valido pulses while idle
  bit               pend = 1'b0;
  int               cnt = 0;
  logic [ANCHO-1:0] dir_mem = '0;

  always begin
    @(negedge clk);
    mem_valido      = 1'b0;
    mem_instruccion = 32'h0;
    if (pend && cnt == 0) begin
      mem_valido      = 1'b1;
      mem_instruccion = dato_de(dir_mem);
      pend            = 1'b0;
    end else if (pend) begin
      cnt = cnt - 1;
    end else if (espurio && $urandom_range(0, 7) == 0) begin
      mem_valido      = 1'b1;
      mem_instruccion = $urandom;
    end
    #2;
    if (mem_peticion && mem_listo) begin
      pend    = 1'b1;
      cnt     = lat - 1;
      dir_mem = mem_direccion;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic paso(input logic rst, input logic listo, input logic det,
                      input logic salto, input logic [63:0] dst);
    @(negedge clk);
    reset           = rst;
    mem_listo       = listo;
    detener         = det;
    salto_tomado    = salto;
    direccion_salto = dst;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus and scoreboard ----------------
  logic [63:0] exp_q[$];  // expected fetch addresses, head = next to be delivered
  logic [63:0] exp_pc;
  logic [63:0] dst;
  logic        l, d, s;
  int          idle;
  int          entregadas;

  initial begin
    // Reset held: outputs at reset values.
    paso(1, 0, 0, 0, 0);
    chk("rst_estado", estado_fsm, 0);
    chk("rst_peticion", mem_peticion, 0);
    chk("rst_valida", instruccion_valida, 0);
    chk("rst_instr", instruccion, 0);
    chk("rst_actualizar", actualizar_pc, 1);
    chk("rst_nueva", nueva_direccion, 64'h0);

    // Release: one idle cycle, PC holds.
    paso(0, 0, 0, 0, 0);
    chk("inactivo_estado", estado_fsm, 0);
    chk("inactivo_actualizar", actualizar_pc, 0);
    chk("inactivo_nueva", nueva_direccion, 64'h0);

    // First fetch at address 0, 1-cycle latency, delivery two cycles later.
    lat = 1;
    paso(0, 1, 0, 0, 0);
    chk("pedir_peticion", mem_peticion, 1);
    chk("pedir_dir", mem_direccion, 64'h0);
    paso(0, 0, 0, 0, 0);
    chk("esperar_valida", instruccion_valida, 0);
    chk("esperar_actualizar", actualizar_pc, 0);
    paso(0, 0, 0, 0, 0);
    chk("entrega0_valida", instruccion_valida, 1);
    chk("entrega0_instr", instruccion, 32'h8B020020);
    chk("entrega0_actualizar", actualizar_pc, 1);
    chk("entrega0_nueva", nueva_direccion, 64'h4);

    // Second fetch at 4, stalled for three cycles then released.
    paso(0, 1, 0, 0, 0);
    chk("pedir4_dir", mem_direccion, 64'h4);
    paso(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      paso(0, 0, 1, 0, 0);
      chk("detener_valida", instruccion_valida, 1);
      chk("detener_instr", instruccion, dato_de(64'h4));
      chk("detener_actualizar", actualizar_pc, 0);
      chk("detener_nueva", nueva_direccion, 64'h4);
    end
    paso(0, 0, 0, 0, 0);
    chk("libera_nueva", nueva_direccion, 64'h8);
    chk("libera_actualizar", actualizar_pc, 1);

    // Redirect to 0x103 while waiting: response dropped, PC goes to 0x100.
    lat = 2;
    paso(0, 1, 0, 0, 0);
    chk("pedir8_dir", mem_direccion, 64'h8);
    paso(0, 0, 0, 1, 64'h103);
    chk("salto_esp_actualizar", actualizar_pc, 0);
    chk("salto_esp_nueva", nueva_direccion, 64'h8);
    paso(0, 0, 0, 0, 0);
    chk("descarte_valida", instruccion_valida, 0);
    chk("descarte_actualizar", actualizar_pc, 1);
    chk("descarte_nueva", nueva_direccion, 64'h100);

    // Immediate redirect in PEDIR without acceptance, then wrap past the top.
    lat = 1;
    paso(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("salto_ped_estado", estado_fsm, 1);
    chk("salto_ped_valida", instruccion_valida, 0);
    chk("salto_ped_actualizar", actualizar_pc, 1);
    chk("salto_ped_nueva", nueva_direccion, 64'hFFFF_FFFF_FFFF_FFFC);
    paso(0, 1, 0, 0, 0);
    chk("pedir_top_dir", mem_direccion, 64'hFFFF_FFFF_FFFF_FFFC);
    paso(0, 0, 0, 0, 0);
    paso(0, 0, 0, 0, 0);
    chk("top_instr", instruccion, dato_de(64'hFFFF_FFFF_FFFF_FFFC));
    chk("top_valida", instruccion_valida, 1);
    chk("top_nueva", nueva_direccion, 64'h0);

    // Redirect and stall together while delivering: redirect wins.
    paso(0, 1, 0, 0, 0);
    paso(0, 0, 0, 0, 0);
    paso(0, 0, 1, 1, 64'h200);
    chk("salto_det_valida", instruccion_valida, 1);
    chk("salto_det_actualizar", actualizar_pc, 1);
    chk("salto_det_nueva", nueva_direccion, 64'h200);

    // Reset pulsed during the wait; the late response must be ignored.
    lat = 2;
    paso(0, 1, 0, 0, 0);
    chk("post_salto_valida", instruccion_valida, 0);
    chk("post_salto_estado", estado_fsm, 1);
    chk("pedir200_dir", mem_direccion, 64'h200);
    paso(1, 0, 0, 0, 0);
    chk("rst_mid_estado", estado_fsm, 0);
    chk("rst_mid_instr", instruccion, 0);
    chk("rst_mid_peticion", mem_peticion, 0);
    chk("rst_mid_nueva", nueva_direccion, 64'h0);
    paso(0, 0, 0, 0, 0);
    chk("tardia_estado", estado_fsm, 0);
    chk("tardia_nueva", nueva_direccion, 64'h0);
    chk("tardia_actualizar", actualizar_pc, 0);
    paso(0, 0, 0, 0, 0);
    chk("tardia_valida", instruccion_valida, 0);
    chk("tardia_pc", pc, 64'h0);

    // Randomized run. The model tracks the address whose instruction must be
    // delivered next: a redirect replaces it, a consumed delivery adds 4.
    espurio    = 1'b1;
    exp_pc     = 64'h0;
    idle       = 0;
    entregadas = 0;
    for (int i = 0; i < 3000; i++) begin
      l   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 2) == 0);
      s   = (i == 0) || ($urandom_range(0, 19) == 0);
      dst = {$urandom, $urandom};
      lat = $urandom_range(1, 3);
      paso(0, l, d, s, dst);
      chk("rnd_dir", mem_direccion, pc);
      if (instruccion_valida) begin
        idle = 0;
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instruccion, dato_de(exp_pc));
        if (s) begin
          chk("rnd_salto_nueva", nueva_direccion, {dst[63:2], 2'b00});
          chk("rnd_salto_act", actualizar_pc, 1);
        end else if (!d) begin
          chk("rnd_avance_nueva", nueva_direccion, exp_pc + 64'd4);
          chk("rnd_avance_act", actualizar_pc, 1);
          entregadas++;
        end else begin
          chk("rnd_hold_nueva", nueva_direccion, pc);
          chk("rnd_hold_act", actualizar_pc, 0);
        end
      end else begin
        idle++;
        if (idle > 60) begin
          chk("rnd_progreso", idle, 0);
          idle = 0;
        end
      end
      if (s) exp_pc = {dst[63:2], 2'b00};
      else if (instruccion_valida && !d) exp_pc = exp_pc + 64'd4;
    end
    chk("rnd_entregas_minimas", (entregadas >= 100), 1);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
